// File: rtl/n64_pif_ram_mp.sv
// Dual-port PIF RAM: port A is a narrow lane view of port B's wide words.
// Zero-fill engine clears the array after reset or on request.
module n64_pif_ram_mp #(
    parameter int WORD_W         = 32,
    parameter int DEPTH          = 512,
    parameter int A_W            = 8,
    parameter int CLEAR_ON_RESET = 1,
    localparam int LANES         = WORD_W / A_W,
    localparam int LW            = $clog2(LANES),
    localparam int AB_W          = $clog2(DEPTH),
    localparam int AA_W          = AB_W + LW
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [AA_W-1:0]   a_addr,
    input  logic              a_wren,
    input  logic              a_oe,
    input  logic [A_W-1:0]    a_data,
    output logic [A_W-1:0]    a_q,
    output logic              a_valid,
    input  logic [AB_W-1:0]   b_addr,
    input  logic              b_wren,
    input  logic [LANES-1:0]  b_be,
    input  logic              b_oe,
    input  logic [WORD_W-1:0] b_data,
    output logic [WORD_W-1:0] b_q,
    output logic              b_valid,
    input  logic              clear_req,
    output logic              busy
);

    typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

    state_t             state_r;
    logic               busy_r;
    logic [AB_W-1:0]    cnt_r;
    logic [WORD_W-1:0]  mem [DEPTH];

    logic [A_W-1:0]     a_q_r;
    logic               a_valid_r;
    logic [WORD_W-1:0]  b_q_r;
    logic               b_valid_r;

    logic [AB_W-1:0]    a_word_s;
    int                 a_pos_s;
    logic               a_ok_s;
    logic               b_ok_s;
    logic               a_we_s;
    logic               b_we_s;
    logic [A_W-1:0]     a_rd_s;
    logic [WORD_W-1:0]  b_rd_s;

    // Lane k is big-endian: lane 0 occupies the most significant bits.
    function automatic logic [A_W-1:0] lane_get(input logic [WORD_W-1:0] w, input int pos);
        return w[pos*A_W +: A_W];
    endfunction

    // Address decode, write qualification and read data selection.
    always_comb begin
        a_word_s = AB_W'(a_addr >> LW);
        a_pos_s  = LANES - 1 - (int'(a_addr) % LANES);
        a_ok_s   = (32'(a_word_s) < 32'(DEPTH));
        b_ok_s   = (32'(b_addr) < 32'(DEPTH));
        a_we_s   = a_wren & a_ok_s & ~busy_r;
        b_we_s   = b_wren & b_ok_s & ~busy_r;
        if (busy_r || !a_ok_s) begin
            a_rd_s = '0;
        end else begin
            a_rd_s = lane_get(mem[a_word_s], a_pos_s);
        end
        if (busy_r || !b_ok_s) begin
            b_rd_s = '0;
        end else begin
            b_rd_s = mem[b_addr];
        end
    end

    // Storage array; port B is written after port A so B wins on shared lanes.
    always_ff @(posedge clk) begin
        if (busy_r) begin
            mem[cnt_r] <= '0;
        end else begin
            if (a_we_s) begin
                mem[a_word_s][a_pos_s*A_W +: A_W] <= a_data;
            end
            for (int p = 0; p < LANES; p++) begin
                if (b_we_s && b_be[p]) begin
                    mem[b_addr][p*A_W +: A_W] <= b_data[p*A_W +: A_W];
                end
            end
        end
    end

    // Zero-fill sequencer; clear_req is ignored while a fill is running.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            busy_r  <= (CLEAR_ON_RESET != 0);
            cnt_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= '0;
                    if (clear_req) begin
                        state_r <= ST_CLEAR;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (32'(cnt_r) == 32'(DEPTH - 1)) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r   <= cnt_r + {{(AB_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // Registered read ports; data holds when no read is requested.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q_r     <= '0;
            a_valid_r <= 1'b0;
            b_q_r     <= '0;
            b_valid_r <= 1'b0;
        end else begin
            a_valid_r <= a_oe;
            b_valid_r <= b_oe;
            if (a_oe) begin
                a_q_r <= a_rd_s;
            end
            if (b_oe) begin
                b_q_r <= b_rd_s;
            end
        end
    end

    assign a_q     = a_q_r;
    assign a_valid = a_valid_r;
    assign b_q     = b_q_r;
    assign b_valid = b_valid_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_n64_pif_ram_mp.sv
// Scoreboard bench for n64_pif_ram_mp: a word-array model predicts read data
// and fill timing; a negedge monitor pops expectations when the DUT answers.
module tb_n64_pif_ram_mp;
    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] a_addr;
    logic        a_wren, a_oe;
    logic [7:0]  a_data;
    logic [7:0]  a_q;
    logic        a_valid;
    logic [8:0]  b_addr;
    logic        b_wren, b_oe;
    logic [3:0]  b_be;
    logic [31:0] b_data;
    logic [31:0] b_q;
    logic        b_valid;
    logic        clear_req;
    logic        busy;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem_m [DEPTH];
    int          fill_left = DEPTH;
    logic        exp_busy = 1'b1;
    logic [7:0]  qa [$];
    logic [31:0] qb [$];

    n64_pif_ram_mp dut (
        .clk(clk), .reset_n(reset_n),
        .a_addr(a_addr), .a_wren(a_wren), .a_oe(a_oe), .a_data(a_data),
        .a_q(a_q), .a_valid(a_valid),
        .b_addr(b_addr), .b_wren(b_wren), .b_be(b_be), .b_oe(b_oe),
        .b_data(b_data), .b_q(b_q), .b_valid(b_valid),
        .clear_req(clear_req), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic idle_in();
        a_addr = '0; a_wren = 1'b0; a_oe = 1'b0; a_data = '0;
        b_addr = '0; b_wren = 1'b0; b_oe = 1'b0; b_be = '0; b_data = '0;
        clear_req = 1'b0;
    endtask

    // One clock of the reference model, driven by the inputs currently applied.
    task automatic tick();
        int aw, ak;
        logic [31:0] amask, bmask;
        if (!reset_n) begin
            fill_left = DEPTH;
        end else begin
            aw = int'(a_addr) / 4;
            ak = int'(a_addr) % 4;
            if (a_oe) qa.push_back(fill_left > 0 ? 8'h00 : 8'(mem_m[aw] >> (8 * (3 - ak))));
            if (b_oe) qb.push_back(fill_left > 0 ? 32'h0 : mem_m[b_addr]);
            if (fill_left > 0) begin
                mem_m[DEPTH - fill_left] = 32'h0;
                fill_left--;
            end else begin
                if (a_wren) begin
                    amask = 32'hFF00_0000 >> (8 * ak);
                    mem_m[aw] = (mem_m[aw] & ~amask) | ({4{a_data}} & amask);
                end
                if (b_wren) begin
                    bmask = {{8{b_be[3]}}, {8{b_be[2]}}, {8{b_be[1]}}, {8{b_be[0]}}};
                    mem_m[b_addr] = (mem_m[b_addr] & ~bmask) | (b_data & bmask);
                end
                if (clear_req) fill_left = DEPTH;
            end
        end
        @(posedge clk);
        exp_busy = (fill_left > 0);
        @(negedge clk);
        #1;
        idle_in();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: busy every cycle, and each read answered exactly one cycle later.
    always @(negedge clk) begin
        logic [7:0]  ea;
        logic [31:0] eb;
        checks++;
        if (busy !== exp_busy) begin
            failures++;
            $display("FAIL busy: got %b expected %b at %0t", busy, exp_busy, $time);
        end
        checks++;
        if (a_valid !== (qa.size() != 0)) begin
            failures++;
            $display("FAIL a_valid: got %b expected %b at %0t", a_valid, qa.size() != 0, $time);
        end
        if (qa.size() != 0) begin
            ea = qa.pop_front();
            checks++;
            if (a_q !== ea) begin
                failures++;
                $display("FAIL a_q: got %h expected %h at %0t", a_q, ea, $time);
            end
        end
        checks++;
        if (b_valid !== (qb.size() != 0)) begin
            failures++;
            $display("FAIL b_valid: got %b expected %b at %0t", b_valid, qb.size() != 0, $time);
        end
        if (qb.size() != 0) begin
            eb = qb.pop_front();
            checks++;
            if (b_q !== eb) begin
                failures++;
                $display("FAIL b_q: got %h expected %h at %0t", b_q, eb, $time);
            end
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
        reset_n = 1'b0;
        idle_in();
        repeat (3) tick();
        chk("reset_a_q", 32'(a_q), 32'h0);
        chk("reset_b_q", b_q, 32'h0);
        chk("reset_valids", {30'h0, a_valid, b_valid}, 32'h0);
        reset_n = 1'b1;
        while (fill_left > 0) tick();

        // Read the top word in the first idle cycle.
        b_oe = 1'b1; b_addr = 9'd511; tick();

        // Full-word write then lane reads.
        b_wren = 1'b1; b_addr = 9'd3; b_data = 32'h1122_3344; b_be = 4'hF; tick();
        for (int i = 12; i < 16; i++) begin a_oe = 1'b1; a_addr = 11'(i); tick(); end

        // Same-word lane contention.
        b_wren = 1'b1; b_addr = 9'd5; b_data = 32'hCAFE_BABE; b_be = 4'hF; tick();
        a_wren = 1'b1; a_addr = 11'd20; a_data = 8'hAA;
        b_wren = 1'b1; b_addr = 9'd5; b_data = 32'h5566_7788; b_be = 4'b1001; tick();
        b_oe = 1'b1; b_addr = 9'd5; tick();
        a_wren = 1'b1; a_addr = 11'd20; a_data = 8'hAA;
        b_wren = 1'b1; b_addr = 9'd5; b_data = 32'h5566_7788; b_be = 4'b0001; tick();
        b_oe = 1'b1; b_addr = 9'd5; tick();
        b_wren = 1'b1; b_addr = 9'd6; b_data = 32'h0102_0304; b_be = 4'b0000; tick();
        b_oe = 1'b1; b_addr = 9'd6; tick();

        // Read-before-write on port B, then port A.
        b_wren = 1'b1; b_oe = 1'b1; b_addr = 9'd7; b_data = 32'hDEAD_BEEF; b_be = 4'hF; tick();
        b_oe = 1'b1; b_addr = 9'd7; tick();
        a_wren = 1'b1; a_oe = 1'b1; a_addr = 11'd29; a_data = 8'h5A; tick();
        a_oe = 1'b1; a_addr = 11'd29; tick();

        // Clear with a dropped write mid-fill and an ignored second request.
        b_wren = 1'b1; b_addr = 9'd9; b_data = 32'h9999_9999; b_be = 4'hF; tick();
        clear_req = 1'b1; tick();
        for (int c = 1; c < 600 && fill_left > 0; c++) begin
            if (c == 50) begin
                b_wren = 1'b1; b_addr = 9'd10; b_data = 32'hFFFF_FFFF; b_be = 4'hF;
                a_wren = 1'b1; a_addr = 11'd44; a_data = 8'h77;
            end
            if (c == 100) clear_req = 1'b1;
            if (c == 300) begin a_oe = 1'b1; a_addr = 11'd36; b_oe = 1'b1; b_addr = 9'd9; end
            tick();
        end
        for (int w = 9; w < 12; w++) begin b_oe = 1'b1; b_addr = 9'(w); tick(); end

        // Reset in the middle of a fill restarts it from word 0.
        b_wren = 1'b1; b_addr = 9'd400; b_data = 32'h1234_5678; b_be = 4'hF; tick();
        clear_req = 1'b1; tick();
        repeat (199) tick();
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        while (fill_left > 0) tick();
        b_oe = 1'b1; b_addr = 9'd400; tick();
        b_oe = 1'b1; b_addr = 9'd0; tick();

        // Randomized traffic, concentrated on a few words to force collisions.
        for (int n = 0; n < 3000; n++) begin
            int w;
            w = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1)) : int'($urandom_range(0, 7));
            a_addr = {9'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            a_wren = 1'($urandom_range(0, 1));
            a_oe   = 1'($urandom_range(0, 1));
            a_data = 8'($urandom);
            b_addr = 9'(w);
            b_wren = 1'($urandom_range(0, 1));
            b_oe   = 1'($urandom_range(0, 1));
            b_be   = 4'($urandom);
            b_data = $urandom;
            clear_req = ($urandom_range(0, 999) == 0);
            tick();
        end
        repeat (2) tick();

        chk("queues_drained", 32'(qa.size() + qb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
